// File: rtl/mem_image_loader.sv
// Byte-stream image loader: assembles MSB-first 32-bit words into the data memory,
// verifies an XOR checksum and releases the CPU reset only after a good load.
module mem_image_loader #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [7:0]        i_byte,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdat,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_cpu_rst_n
);

   localparam int unsigned CAP_WORDS = (DEPTH - BASE_ADDR) / 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        xor_q;
   logic [7:0]        words_left_q;
   logic [1:0]        byte_cnt_q;
   logic [23:0]       asm_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdat_q;

   logic              in_frame_c;
   logic              can_start_c;
   logic              xfer_c;
   logic              word_done_c;

   always_comb begin
      in_frame_c  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
      can_start_c = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
      xfer_c      = i_valid && in_frame_c;
      word_done_c = xfer_c && (state_q == S_DATA) && (byte_cnt_q == 2'd3);
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (i_start) state_d = S_HDR;
         end
         S_HDR: begin
            if (xfer_c) begin
               if (i_byte == 8'd0)                     state_d = S_CSUM;
               else if (32'(i_byte) > CAP_WORDS)       state_d = S_ERR;
               else                                    state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (word_done_c && (words_left_q == 8'd1)) state_d = S_CSUM;
         end
         S_CSUM: begin
            if (xfer_c) state_d = (i_byte == xor_q) ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: word assembly, checksum fold and the one-cycle DM write
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr_q       <= '0;
         xor_q        <= '0;
         words_left_q <= '0;
         byte_cnt_q   <= '0;
         asm_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdat_q   <= '0;
      end else begin
         mem_we_q <= 1'b0;
         if (can_start_c && i_start) begin
            addr_q <= ADDR_W'(BASE_ADDR);
            xor_q  <= 8'd0;
         end
         if (xfer_c && (state_q == S_HDR)) begin
            words_left_q <= i_byte;
            byte_cnt_q   <= 2'd0;
         end
         if (xfer_c && (state_q == S_DATA)) begin
            asm_q      <= {asm_q[15:0], i_byte};
            xor_q      <= xor_q ^ i_byte;
            byte_cnt_q <= byte_cnt_q + 2'd1;
         end
         if (word_done_c) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= addr_q;
            mem_wdat_q   <= {asm_q, i_byte};
            addr_q       <= addr_q + ADDR_W'(4);
            words_left_q <= words_left_q - 8'd1;
         end
      end
   end

   // Status outputs decode straight from the state register
   assign o_ready     = in_frame_c;
   assign o_busy      = in_frame_c;
   assign o_done      = (state_q == S_DONE);
   assign o_err       = (state_q == S_ERR);
   assign o_cpu_rst_n = (state_q == S_DONE);
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdat  = mem_wdat_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// Randomized bench for mem_image_loader: frames are scored against a queue-based
// model of the expected DM writes and final status.
module tb_mem_image_loader;

   localparam int unsigned ADDR_W = 8;
   localparam int CAP = 64;

   logic              tb_i_clk = 1'b0;
   logic              i_rst, i_start, i_valid;
   logic [7:0]        i_byte;
   logic              o_ready, o_mem_we, o_busy, o_done, o_err, o_cpu_rst_n;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0]       o_mem_wdat;

   int          n_vec = 0;
   int          n_fail = 0;
   logic [39:0] wr_q[$];
   logic [31:0] img[256];

   always #5 tb_i_clk = ~tb_i_clk;

   mem_image_loader dut (
      .i_clk       (tb_i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_byte      (i_byte),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdat  (o_mem_wdat),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_cpu_rst_n (o_cpu_rst_n)
   );

   // Capture every cycle the write strobe is high
   always @(posedge tb_i_clk) begin
      if (o_mem_we === 1'b1) wr_q.push_back({o_mem_addr, o_mem_wdat});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge tb_i_clk);
         #1;
      end
   endtask

   task automatic check_status(input string tag, input bit busy, input bit done,
                               input bit err, input bit ready);
      check({tag, ".busy"},  64'(o_busy),      64'(busy));
      check({tag, ".done"},  64'(o_done),      64'(done));
      check({tag, ".err"},   64'(o_err),       64'(err));
      check({tag, ".cpu"},   64'(o_cpu_rst_n), 64'(done));
      check({tag, ".ready"}, 64'(o_ready),     64'(ready));
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_byte = 8'h00;
      tick(2);
      i_rst = 1'b0;
   endtask

   // Start pulse with a junk valid byte that must be ignored
   task automatic start_load(input string tag);
      i_start = 1'b1; i_valid = 1'b1; i_byte = 8'hA5;
      tick(1);
      i_start = 1'b0; i_valid = 1'b0;
      check_status({tag, ".start"}, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit noise);
      int guard = 0;
      while ((int'($urandom_range(99)) < gap_pct) && (guard < 6)) begin
         i_valid = 1'b0;
         i_byte  = 8'($urandom);
         i_start = noise ? 1'($urandom_range(1)) : 1'b0;
         tick(1);
         guard++;
      end
      i_valid = 1'b1;
      i_byte  = b;
      i_start = noise ? 1'($urandom_range(1)) : 1'b0;
      tick(1);
      i_valid = 1'b0;
      i_start = 1'b0;
   endtask

   function automatic logic [7:0] img_xor(input int n);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < n; i++) x ^= img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
      return x;
   endfunction

   task automatic run_frame(input string tag, input int n, input logic [7:0] c,
                            input int gap_pct, input bit noise);
      bit good;
      logic [31:0] w;
      wr_q.delete();
      start_load(tag);
      send_byte(8'(n), gap_pct, noise);
      if (n > CAP) begin
         tick(2);
         check({tag, ".nwr"}, 64'(wr_q.size()), 64'd0);
         check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap_pct, noise);
      end
      send_byte(c, gap_pct, noise);
      tick(2);
      good = (c == img_xor(n));
      check({tag, ".nwr"}, 64'(wr_q.size()), 64'(n));
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
         check($sformatf("%s.wr%0d", tag, i), 64'(wr_q[i]), 64'({8'(4 * i), img[i]}));
      end
      check_status(tag, 1'b0, good, !good, 1'b0);
   endtask

   initial begin
      do_reset();
      check("rst.we",   64'(o_mem_we),   64'd0);
      check("rst.addr", 64'(o_mem_addr), 64'd0);
      check("rst.wdat", 64'(o_mem_wdat), 64'd0);
      check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);

      img[0] = 32'h12345678;
      run_frame("t1", 1, 8'h08, 0, 1'b0);

      img[0] = 32'h1; img[1] = 32'h2; img[2] = 32'h3;
      run_frame("t2", 3, 8'h00, 0, 1'b0);

      img[0] = 32'hCAFE0001; img[1] = 32'hCAFE0001;
      run_frame("t3", 2, 8'hFF, 0, 1'b0);

      run_frame("t4", 65, 8'h00, 0, 1'b0);
      run_frame("t4b", 0, 8'h00, 0, 1'b0);

      // Reset in the middle of the second word
      img[0] = 32'hDEADBEEF; img[1] = 32'h01020304;
      wr_q.delete();
      start_load("t5");
      send_byte(8'd2, 0, 1'b0);
      for (int k = 3; k >= 0; k--) send_byte(img[0][8*k +: 8], 0, 1'b0);
      send_byte(img[1][31:24], 0, 1'b0);
      send_byte(img[1][23:16], 0, 1'b0);
      i_rst = 1'b1;
      tick(1);
      i_rst = 1'b0;
      tick(2);
      check("t5.nwr", 64'(wr_q.size()), 64'd1);
      if (wr_q.size() > 0) check("t5.wr0", 64'(wr_q[0]), 64'({8'h00, 32'hDEADBEEF}));
      check("t5.we",   64'(o_mem_we),   64'd0);
      check("t5.addr", 64'(o_mem_addr), 64'd0);
      check("t5.wdat", 64'(o_mem_wdat), 64'd0);
      check_status("t5", 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame("t5b", 2, img_xor(2), 0, 1'b0);

      // Random images, gaps and spurious starts
      for (int f = 0; f < 24; f++) begin
         int n;
         logic [7:0] c;
         n = (f % 6 == 5) ? int'($urandom_range(65, 255)) : int'($urandom_range(0, CAP));
         if (f == 2) n = CAP;
         for (int i = 0; i < 256; i++) img[i] = $urandom;
         c = img_xor((n > CAP) ? 0 : n);
         if ($urandom_range(3) == 0) c ^= 8'($urandom_range(1, 255));
         run_frame($sformatf("r%0d", f), n, c, int'($urandom_range(0, 60)), f[0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
